// File: rtl/constant_value_checker.sv
// constant_value_checker
//
// Sink-side checker for a bus that should carry a fixed constant. Every enabled
// cycle it samples data_in and compares it against VALUE (truncated to W bits).
// The checker declares lock after LOCK_COUNT consecutive matches. Any mismatch
// while locked moves it to a sticky error state, and clear_error releases it.
// Two saturating counters record enabled matching and mismatching samples.
//
// Parameters:
//   W          - data bus width in bits
//   VALUE      - expected constant, truncated to W bits
//   LOCK_COUNT - consecutive matches needed to lock (1..255)
//   CNT_W      - width of each statistics counter
//
// Ports:
//   clk                 - rising-edge clock
//   reset_synchronous_n - synchronous active-low reset
//   enable              - 1 = sample data_in this cycle, 0 = freeze state and counters
//   data_in             - bus under check
//   clear_error         - single-cycle request to leave ERROR and restart the search
//   match               - registered: last enabled sample equalled VALUE
//   locked              - registered: checker is locked
//   error               - registered, sticky: checker saw a mismatch while locked
//   match_count         - saturating count of enabled matching samples
//   mismatch_count      - saturating count of enabled mismatching samples

module constant_value_checker #(
    parameter int unsigned     W          = 32,
    parameter longint unsigned VALUE      = 5,
    parameter int unsigned     LOCK_COUNT = 4,
    parameter int unsigned     CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_synchronous_n,
    input  logic             enable,
    input  logic [W-1:0]     data_in,
    input  logic             clear_error,
    output logic             match,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] mismatch_count
);

    localparam logic [W-1:0]     ExpValue   = W'(VALUE);
    localparam logic [8:0]       LockTarget = 9'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] CntMax     = '1;

    typedef enum logic [1:0] {
        StSearch,
        StLocking,
        StLocked,
        StError
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       run_q, run_d;
    logic             match_q, match_d;
    logic             locked_q, locked_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
    logic             hit;
    logic [8:0]       run_next;

    assign hit      = (data_in == ExpValue);
    // Widened so the lock comparison works for LOCK_COUNT up to 255.
    assign run_next = {1'b0, run_q} + 9'd1;

    always_comb begin
        state_d        = state_q;
        run_d          = run_q;
        match_d        = match_q;
        match_cnt_d    = match_cnt_q;
        mismatch_cnt_d = mismatch_cnt_q;

        if (enable) begin
            match_d = hit;

            if (hit) begin
                if (match_cnt_q != CntMax) begin
                    match_cnt_d = match_cnt_q + 1'b1;
                end
            end else begin
                if (mismatch_cnt_q != CntMax) begin
                    mismatch_cnt_d = mismatch_cnt_q + 1'b1;
                end
            end

            unique case (state_q)
                StSearch: begin
                    if (hit) begin
                        if (LockTarget == 9'd1) begin
                            state_d = StLocked;
                            run_d   = 8'd0;
                        end else begin
                            state_d = StLocking;
                            run_d   = 8'd1;
                        end
                    end else begin
                        run_d = 8'd0;
                    end
                end
                StLocking: begin
                    if (hit) begin
                        if (run_next == LockTarget) begin
                            state_d = StLocked;
                            run_d   = 8'd0;
                        end else begin
                            run_d = run_next[7:0];
                        end
                    end else begin
                        state_d = StSearch;
                        run_d   = 8'd0;
                    end
                end
                StLocked: begin
                    if (!hit) begin
                        state_d = StError;
                    end
                end
                StError: begin
                    // Sticky: only clear_error leaves this state.
                end
                default: begin
                    state_d = StSearch;
                    run_d   = 8'd0;
                end
            endcase
        end

        // Honoured even when disabled; overrides the enabled sample so that sample
        // is counted but never starts a run.
        if (clear_error && (state_q == StError)) begin
            state_d = StSearch;
            run_d   = 8'd0;
        end

        locked_d = (state_d == StLocked);
        error_d  = (state_d == StError);
    end

    always_ff @(posedge clk) begin
        if (!reset_synchronous_n) begin
            state_q        <= StSearch;
            run_q          <= 8'd0;
            match_q        <= 1'b0;
            locked_q       <= 1'b0;
            error_q        <= 1'b0;
            match_cnt_q    <= '0;
            mismatch_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            run_q          <= run_d;
            match_q        <= match_d;
            locked_q       <= locked_d;
            error_q        <= error_d;
            match_cnt_q    <= match_cnt_d;
            mismatch_cnt_q <= mismatch_cnt_d;
        end
    end

    assign match          = match_q;
    assign locked         = locked_q;
    assign error          = error_q;
    assign match_count    = match_cnt_q;
    assign mismatch_count = mismatch_cnt_q;

endmodule

// File: tb/tb_constant_value_checker.sv
// Directed bench for constant_value_checker. A default instance (VALUE=5,
// LOCK_COUNT=4, CNT_W=16) and a small instance (LOCK_COUNT=1, CNT_W=4) share
// the same stimulus; the small one covers counter saturation and single-hit lock.

module tb_constant_value_checker;

    logic        clk;
    logic        reset_synchronous_n;
    logic        enable;
    logic [31:0] data_in;
    logic        clear_error;

    logic        match, locked, error;
    logic [15:0] match_count, mismatch_count;

    logic        s_match, s_locked, s_error;
    logic [3:0]  s_match_count, s_mismatch_count;

    int unsigned n_vec;
    int unsigned n_err;

    constant_value_checker #(
        .W         (32),
        .VALUE     (5),
        .LOCK_COUNT(4),
        .CNT_W     (16)
    ) u_dut (
        .clk                (clk),
        .reset_synchronous_n(reset_synchronous_n),
        .enable             (enable),
        .data_in            (data_in),
        .clear_error        (clear_error),
        .match              (match),
        .locked             (locked),
        .error              (error),
        .match_count        (match_count),
        .mismatch_count     (mismatch_count)
    );

    constant_value_checker #(
        .W         (32),
        .VALUE     (5),
        .LOCK_COUNT(1),
        .CNT_W     (4)
    ) u_dut_small (
        .clk                (clk),
        .reset_synchronous_n(reset_synchronous_n),
        .enable             (enable),
        .data_in            (data_in),
        .clear_error        (clear_error),
        .match              (s_match),
        .locked             (s_locked),
        .error              (s_error),
        .match_count        (s_match_count),
        .mismatch_count     (s_mismatch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one set of inputs across a rising edge and return #1 after it.
    task automatic cyc(input logic rst_n, input logic en, input logic [31:0] d,
                       input logic clr);
        reset_synchronous_n = rst_n;
        enable              = en;
        data_in             = d;
        clear_error         = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic m, input logic l, input logic e,
                             input int unsigned mc, input int unsigned mmc);
        check({tag, ".match"}, {31'd0, match}, {31'd0, m});
        check({tag, ".locked"}, {31'd0, locked}, {31'd0, l});
        check({tag, ".error"}, {31'd0, error}, {31'd0, e});
        check({tag, ".match_count"}, {16'd0, match_count}, mc);
        check({tag, ".mismatch_count"}, {16'd0, mismatch_count}, mmc);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_synchronous_n = 1'b0;
        enable = 1'b0;
        data_in = '0;
        clear_error = 1'b0;
        #2;

        // Reset held two cycles with matching data present.
        cyc(1'b0, 1'b1, 32'd5, 1'b0);
        cyc(1'b0, 1'b1, 32'd5, 1'b0);
        check_all("reset", 1'b0, 1'b0, 1'b0, 0, 0);
        check("reset.small_mc", {28'd0, s_match_count}, 32'd0);

        // Lock sequence: four 5s.
        cyc(1'b1, 1'b1, 32'd5, 1'b0);
        check_all("lock1", 1'b1, 1'b0, 1'b0, 1, 0);
        check("lock1.small_locked", {31'd0, s_locked}, 32'd1);
        cyc(1'b1, 1'b1, 32'd5, 1'b0);
        cyc(1'b1, 1'b1, 32'd5, 1'b0);
        check("lock3.locked", {31'd0, locked}, 32'd0);
        cyc(1'b1, 1'b1, 32'd5, 1'b0);
        check_all("lock4", 1'b1, 1'b1, 1'b0, 4, 0);

        // Broken run: 5,5,5,7,5,5,5,5.
        cyc(1'b0, 1'b1, 32'd5, 1'b0);
        cyc(1'b1, 1'b1, 32'd5, 1'b0);
        cyc(1'b1, 1'b1, 32'd5, 1'b0);
        cyc(1'b1, 1'b1, 32'd5, 1'b0);
        cyc(1'b1, 1'b1, 32'd7, 1'b0);
        check_all("broken4", 1'b0, 1'b0, 1'b0, 3, 1);
        cyc(1'b1, 1'b1, 32'd5, 1'b0);
        cyc(1'b1, 1'b1, 32'd5, 1'b0);
        cyc(1'b1, 1'b1, 32'd5, 1'b0);
        check("broken7.locked", {31'd0, locked}, 32'd0);
        cyc(1'b1, 1'b1, 32'd5, 1'b0);
        check_all("broken8", 1'b1, 1'b1, 1'b0, 7, 1);

        // Mismatch while locked -> sticky error.
        cyc(1'b1, 1'b1, 32'd0, 1'b0);
        check_all("err", 1'b0, 1'b0, 1'b1, 7, 2);
        cyc(1'b1, 1'b1, 32'd5, 1'b0);
        cyc(1'b1, 1'b1, 32'd5, 1'b0);
        check_all("err_sticky", 1'b1, 1'b0, 1'b1, 9, 2);

        // clear_error while disabled: leaves ERROR, counters and match frozen.
        cyc(1'b1, 1'b0, 32'd0, 1'b1);
        check_all("clr_dis", 1'b1, 1'b0, 1'b0, 9, 2);
        cyc(1'b1, 1'b1, 32'd5, 1'b0);
        cyc(1'b1, 1'b1, 32'd5, 1'b0);
        cyc(1'b1, 1'b1, 32'd5, 1'b0);
        check("relock3.locked", {31'd0, locked}, 32'd0);
        cyc(1'b1, 1'b1, 32'd5, 1'b0);
        check_all("relock4", 1'b1, 1'b1, 1'b0, 13, 2);

        // clear_error with an enabled hit: counted, but does not start a run.
        cyc(1'b1, 1'b1, 32'd0, 1'b0);
        check("err2.error", {31'd0, error}, 32'd1);
        cyc(1'b1, 1'b1, 32'd5, 1'b1);
        check_all("clr_en", 1'b1, 1'b0, 1'b0, 14, 3);
        cyc(1'b1, 1'b1, 32'd5, 1'b0);
        cyc(1'b1, 1'b1, 32'd5, 1'b0);
        cyc(1'b1, 1'b1, 32'd5, 1'b0);
        check("clr_en3.locked", {31'd0, locked}, 32'd0);
        cyc(1'b1, 1'b1, 32'd5, 1'b0);
        check_all("clr_en4", 1'b1, 1'b1, 1'b0, 18, 3);

        // clear_error outside ERROR has no effect.
        cyc(1'b1, 1'b1, 32'd5, 1'b1);
        check_all("clr_locked", 1'b1, 1'b1, 1'b0, 19, 3);

        // Enable freeze with mismatching data.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 32'd9, 1'b0);
        end
        check_all("freeze", 1'b1, 1'b1, 1'b0, 19, 3);

        // Reset from ERROR.
        cyc(1'b1, 1'b1, 32'd0, 1'b0);
        check_all("err3", 1'b0, 1'b0, 1'b1, 19, 4);
        cyc(1'b0, 1'b1, 32'd5, 1'b0);
        check_all("rst_err", 1'b0, 1'b0, 1'b0, 0, 0);

        // Saturation: 20 matches, small counters stop at 15.
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1, 32'd5, 1'b0);
        end
        check("sat.small_mc", {28'd0, s_match_count}, 32'd15);
        check("sat.small_mmc", {28'd0, s_mismatch_count}, 32'd0);
        check("sat.mc", {16'd0, match_count}, 32'd20);

        // Small instance: one miss while locked -> error; its mismatch counter counts.
        cyc(1'b1, 1'b1, 32'd6, 1'b0);
        check("sat.small_error", {31'd0, s_error}, 32'd1);
        check("sat.small_mmc1", {28'd0, s_mismatch_count}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
